// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, grant width
// and the round-robin pointer wrap helper.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int GRANT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT
  } arb_state_e;

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] v, input int n);
    if (int'(v) >= n - 1) return '0;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bundle: one valid/data/last/ready lane per source.
// The arbiter takes the slave modport, the byte formatters take master.
interface uart_tx_arbiter_if #(parameter int N_REQ = 2);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave  (input req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping at N_REQ-1.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               any_valid
);

  logic found;
  int   idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = GRANT_W'(idx);
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte sources with message-granular round-robin;
// a grant is held until the byte flagged last has left the wire.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int BUSY_WAIT    = 16,
  parameter int LOCK_TIMEOUT = 1200000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   req_if,
  output logic [7:0]         tx_data,
  output logic               tx_data_valid,
  input  logic               tx_busy,
  output logic [GRANT_W-1:0] grant_id,
  output logic               locked,
  output logic               err_lost
);

  localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int BUSY_W = $clog2(BUSY_WAIT + 1);
  localparam int IDX_W  = $clog2(N_REQ);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(LOCK_TIMEOUT - 1);
  localparam logic [BUSY_W-1:0] BUSY_LIM = BUSY_W'(BUSY_WAIT - 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic               locked_q, locked_d;
  logic               last_q, last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               err_q, err_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;

  logic [GRANT_W-1:0] winner;
  logic               any_valid;
  logic [IDX_W-1:0]   g_idx;
  logic               do_release;

  assign g_idx = grant_q[IDX_W-1:0];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req_if.req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    locked_d   = locked_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    ready_d    = '0;
    err_d      = 1'b0;
    idle_cnt_d = idle_cnt_q;
    busy_cnt_d = busy_cnt_q;
    do_release = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid && !tx_busy) begin
          grant_d    = winner;
          locked_d   = 1'b1;
          idle_cnt_d = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_if.req_valid[g_idx]) begin
          tx_data_d      = req_if.req_data[{g_idx, 3'b000} +: 8];
          tx_valid_d     = 1'b1;
          ready_d[g_idx] = 1'b1;
          last_d         = req_if.req_last[g_idx];
          idle_cnt_d     = '0;
          busy_cnt_d     = '0;
          state_d        = ST_WAIT_HI;
        end else if (idle_cnt_q >= IDLE_LIM) begin
          err_d      = 1'b1;
          do_release = 1'b1;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      // A byte that never raises busy is counted as sent so the message can finish.
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (busy_cnt_q >= BUSY_LIM) begin
          err_d   = 1'b1;
          state_d = ST_NEXT;
        end else if (busy_cnt_q != '1) begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (last_q) do_release = 1'b1;
        else        state_d    = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_release) begin
      locked_d = 1'b0;
      ptr_d    = wrap_inc(grant_q, N_REQ);
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ready_q    <= '0;
      err_q      <= 1'b0;
      idle_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      idle_cnt_q <= idle_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign tx_data          = tx_data_q;
  assign tx_data_valid    = tx_valid_q;
  assign req_if.req_ready = ready_q;
  assign grant_id         = grant_q;
  assign locked           = locked_q;
  assign err_lost         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, a behavioural uart_tx busy
// model that logs the byte stream, and a round-robin reference for grant order.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N     = 2;
  localparam int BW    = 16;
  localparam int LT    = 100;
  localparam int FRAME = 20;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]         tx_data;
  logic               tx_data_valid;
  logic               tx_busy;
  logic [GRANT_W-1:0] grant_id;
  logic               locked;
  logic               err_lost;

  uart_tx_arbiter_if #(.N_REQ(N)) arb_if ();

  uart_tx_arbiter #(.N_REQ(N), .BUSY_WAIT(BW), .LOCK_TIMEOUT(LT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_if        (arb_if.slave),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .locked        (locked),
    .err_lost      (err_lost)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] lane_q[N][$];
  logic [7:0] wire_q[$];
  logic [7:0] exp_wire[$];
  int grant_log[$];
  int exp_grant[$];
  int ready_cnt[N];
  int bad_ready = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;
  int model_ptr = 0;
  bit stub = 1'b0;
  logic prev_locked = 1'b0;

  // Stand-in for uart_tx: busy for FRAME cycles after each accepted byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_data_valid && !stub) begin
      wire_q.push_back(tx_data);
      tx_busy  <= 1'b1;
      busy_cnt <= FRAME;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  // Requesters: present the queue head, advance when ready is seen.
  always @(negedge clk) begin
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_if.req_ready[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      if (lane_q[i].size() > 0) begin
        v[i]       = 1'b1;
        d[8*i +: 8] = lane_q[i][0][7:0];
        l[i]       = lane_q[i][0][8];
      end
    end
    arb_if.req_valid = v;
    arb_if.req_data  = d;
    arb_if.req_last  = l;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) if (arb_if.req_ready[i]) ready_cnt[i]++;
      if ((arb_if.req_ready & ~(N'(1) << grant_id)) != '0) bad_ready++;
      if ($countones(arb_if.req_ready) > 1) bad_ready++;
      if (tx_data_valid) valid_cnt++;
      if (locked && !prev_locked) grant_log.push_back(int'(grant_id));
    end
    prev_locked = locked;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    return q;
  endfunction

  function automatic bq_t randMsg();
    bq_t q;
    int len;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic applyStimulus(input int lane, input bq_t m, input bit with_last);
    for (int i = 0; i < m.size(); i++)
      lane_q[lane].push_back({with_last && (i == m.size() - 1), m[i]});
  endtask

  task automatic expectMsg(input bq_t m);
    for (int i = 0; i < m.size(); i++) exp_wire.push_back(m[i]);
  endtask

  task automatic clearLogs();
    wire_q.delete();
    exp_wire.delete();
    grant_log.delete();
    exp_grant.delete();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    repeat (3) @(posedge clk);
    #1;
    clearLogs();
    model_ptr = 0;
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((lane_q[0].size() > 0 || lane_q[1].size() > 0 || locked || tx_busy) && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_done"}, 64'(n < 6000), 64'd1);
  endtask

  task automatic checkWire(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_wire.size(); i++)
      if (i >= wire_q.size() || wire_q[i] !== exp_wire[i]) mism++;
    checkOutput({tag, "_wire_len"}, 64'(wire_q.size()), 64'(exp_wire.size()));
    checkOutput({tag, "_wire_bytes"}, 64'(mism), 64'd0);
  endtask

  task automatic checkGrants(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_grant.size(); i++)
      if (i >= grant_log.size() || grant_log[i] != exp_grant[i]) mism++;
    checkOutput({tag, "_grant_len"}, 64'(grant_log.size()), 64'(exp_grant.size()));
    checkOutput({tag, "_grant_order"}, 64'(mism), 64'd0);
  endtask

  task automatic waitCycles(input int limit, output int n);
    n = 0;
    @(posedge clk);
    #1;
    n = 1;
  endtask

  initial begin
    bq_t m0, m1;
    int n, sel, base;

    arb_if.req_valid = '0;
    arb_if.req_data  = '0;
    arb_if.req_last  = '0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;

    // Reset values
    #2;
    checkOutput("reset_outputs",
                64'({tx_data, tx_data_valid, arb_if.req_ready, grant_id, locked, err_lost}), 64'd0);
    applyReset();

    // Lone message on lane 0, plus first-byte latency
    m0 = str2q("CHAL:1A2B\n");
    @(posedge clk); #1;
    applyStimulus(0, m0, 1'b1);
    expectMsg(m0);
    n = 0;
    while (!tx_data_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t1_latency", 64'(n), 64'd2);
    waitIdle("t1");
    checkWire("t1");
    checkOutput("t1_ready0", 64'(ready_cnt[0]), 64'd10);
    checkOutput("t1_ready1", 64'(ready_cnt[1]), 64'd0);
    checkOutput("t1_locked", 64'(locked), 64'd0);
    checkOutput("t1_grant_hold", 64'(grant_id), 64'd0);

    // Simultaneous start, then randomized rounds against the round-robin model
    applyReset();
    for (int r = 0; r < 7; r++) begin
      clearLogs();
      if (r == 0) begin
        sel = 2;
        m0 = str2q("AB\n");
        m1 = str2q("XY\n");
      end else begin
        sel = $urandom_range(0, 2);
        m0 = randMsg();
        m1 = randMsg();
      end
      @(posedge clk); #1;
      if (sel != 1) applyStimulus(0, m0, 1'b1);
      if (sel != 0) applyStimulus(1, m1, 1'b1);
      if (sel == 2) begin
        exp_grant.push_back(model_ptr);
        exp_grant.push_back(1 - model_ptr);
        if (model_ptr == 0) begin expectMsg(m0); expectMsg(m1); end
        else begin expectMsg(m1); expectMsg(m0); end
      end else begin
        exp_grant.push_back(sel);
        expectMsg(sel == 0 ? m0 : m1);
        model_ptr = (sel + 1) % N;
      end
      waitIdle($sformatf("rr%0d", r));
      checkWire($sformatf("rr%0d", r));
      checkGrants($sformatf("rr%0d", r));
    end

    // Lane 0 requests in the middle of lane 1's message
    clearLogs();
    @(posedge clk); #1;
    applyStimulus(1, str2q("RESP\n"), 1'b1);
    n = 0;
    while (ready_cnt[1] < 2 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    applyStimulus(0, str2q("ok\n"), 1'b1);
    expectMsg(str2q("RESP\n"));
    expectMsg(str2q("ok\n"));
    exp_grant.push_back(1);
    exp_grant.push_back(0);
    waitIdle("t3");
    checkWire("t3");
    checkGrants("t3");
    model_ptr = 1;

    // Grantee stalls mid-message: forced release after LT idle cycles
    clearLogs();
    @(posedge clk); #1;
    applyStimulus(0, str2q("abc"), 1'b0);
    n = 0;
    while (ready_cnt[0] < 3 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    applyStimulus(1, str2q("Z\n"), 1'b1);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (tx_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (!err_lost && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t4_timeout_cycles", 64'(n), 64'(LT + 2));
    checkOutput("t4_locked_at_err", 64'(locked), 64'd0);
    expectMsg(str2q("abcZ\n"));
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    waitIdle("t4");
    checkWire("t4");
    checkGrants("t4");
    model_ptr = 0;

    // Busy never rises: each byte declared lost after BW cycles
    clearLogs();
    @(posedge clk); #1;
    stub = 1'b1;
    applyStimulus(0, str2q("PQ"), 1'b1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!tx_data_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      n = 0;
      while (!err_lost && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput($sformatf("t5_busy_wait%0d", k), 64'(n), 64'(BW));
    end
    waitIdle("t5");
    checkOutput("t5_ready0", 64'(ready_cnt[0]), 64'd2);
    stub = 1'b0;

    // Asynchronous reset in the middle of the 4th byte's frame
    clearLogs();
    @(posedge clk); #1;
    applyStimulus(1, str2q("abcdef"), 1'b1);
    base = valid_cnt;
    n = 0;
    while (valid_cnt < base + 4 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset",
                64'({tx_data, tx_data_valid, arb_if.req_ready, grant_id, locked, err_lost}), 64'd0);
    applyReset();
    m0 = randMsg();
    m1 = randMsg();
    @(posedge clk); #1;
    applyStimulus(0, m0, 1'b1);
    applyStimulus(1, m1, 1'b1);
    expectMsg(m0);
    expectMsg(m1);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    waitIdle("t6");
    checkWire("t6");
    checkGrants("t6");

    checkOutput("ready_to_grantee_only", 64'(bad_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
